clock_set_ctrl: RTL
===================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameters: ALARM_HH_INIT, 8'h06, BCD alarm hour after reset; ALARM_MM_INIT, 8'h00, BCD alarm minute after reset.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 tick  in  1  one-cycle 1 Hz enable; drives blink only.
REQ-005 btn_mode  in  1  debounced one-cycle pulse; advances time-set sequence.
REQ-006 btn_alarm  in  1  debounced one-cycle pulse; enters or advances alarm-set sequence.
REQ-007 btn_inc  in  1  debounced one-cycle pulse; increments the selected field.
REQ-008 cur_hh, cur_mm, cur_ss  in  8 each  live BCD time from the clock counter.
REQ-009 run_en  out  1  counter count enable.
REQ-010 load  out  1  one-cycle strobe; counter takes ld_hh/ld_mm/ld_ss.
REQ-011 ld_hh, ld_mm, ld_ss  out  8 each  BCD load values, valid while load=1.
REQ-012 state  out  3  current FSM state encoding.
REQ-013 blink  out  1  display blink phase for the selected field.
REQ-014 alarm_hit  out  1  one-cycle alarm pulse.

Function
REQ-015 The FSM SHALL use states RUN=0, SET_HH=1, SET_MM=2, SET_SS=3, COMMIT=4, AL_HH=5, AL_MM=6.
REQ-016 In RUN, btn_mode SHALL capture cur_hh/mm/ss into edit_hh/mm/ss and move to SET_HH in the same edge.
REQ-017 The time-set sequence SHALL advance on btn_mode: SET_HH->SET_MM->SET_SS->COMMIT.
REQ-018 COMMIT SHALL last exactly one cycle, assert load=1 with ld_*=edit_*, then return to RUN.
REQ-019 In RUN, btn_alarm SHALL move to AL_HH.
REQ-020 The alarm-set sequence SHALL advance on btn_alarm: AL_HH->AL_MM->RUN, with no load pulse.
REQ-021 btn_mode in AL_* and btn_alarm in SET_* SHALL be ignored.
REQ-022 btn_inc SHALL increment the selected field by one in BCD; in RUN and COMMIT it SHALL be ignored.
REQ-023 Wrap rules: hour fields 8'h23->8'h00; minute/second fields 8'h59->8'h00; low nibble 9->0 carries into the high nibble.
REQ-024 An increment SHALL never produce a non-BCD value.
REQ-025 If btn_inc coincides with btn_mode or btn_alarm, the advance SHALL take effect and the increment SHALL be dropped.
REQ-026 run_en SHALL be 1 only in RUN, so the counter holds while setting and during COMMIT.
REQ-027 load SHALL be 0 in every state except COMMIT.
REQ-028 blink SHALL be 0 in RUN.
REQ-029 In any set state, blink SHALL toggle on each tick and reset to 0 on every state change.
REQ-030 alarm_hit SHALL pulse for one cycle on the rising edge of the condition (state==RUN and cur_hh==al_hh and cur_mm==al_mm and cur_ss==8'h00).
REQ-031 Outside RUN the alarm match condition SHALL be held false; this also applies to the cycle that registers the previous match value.
REQ-032 al_hh/al_mm SHALL change only through btn_inc in AL_HH/AL_MM.
REQ-033 All outputs SHALL be registered; responses appear one cycle after the triggering input edge.

Reset
REQ-034 On reset=1 at a clock edge: state=RUN, run_en=1, load=0, ld_*=0, blink=0, alarm_hit=0, edit_*=0, al_hh=ALARM_HH_INIT, al_mm=ALARM_MM_INIT.
REQ-035 Reset during any set state or COMMIT SHALL abort the sequence with no load pulse; reset overrides all buttons in that cycle.

Verification
REQ-036 Time set: cur=12:34:56, btn_mode, inc x2, mode, mode, mode -> exactly one load with ld=14:34:56; run_en=0 from SET_HH through COMMIT, then 1.
REQ-037 Wrap: SET_HH with edit_hh=8'h23, btn_inc -> 8'h00; SET_MM 8'h59 +1 -> 8'h00; SET_SS 8'h09 +1 -> 8'h10.
REQ-038 Collision: btn_mode and btn_inc in the same cycle in SET_MM -> state SET_SS, edit_mm unchanged.
REQ-039 Alarm: set al=07:30 via btn_alarm/inc, then drive cur 07:29:59->07:30:00 in RUN -> one alarm_hit pulse, no repeat while cur stays 07:30:00.
REQ-040 Reset mid-set: reset in SET_SS after edits -> state RUN, load never asserted, al_hh=8'h06, al_mm=8'h00.
REQ-041 Blink: in SET_HH apply 3 ticks -> blink sequence 1,0,1; btn_mode -> blink 0.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time/alarm setting controller for a BCD wall clock.
// Sequences the time-set and alarm-set menus, edits the selected BCD field,
// loads the edited time into the clock counter, and detects the alarm time.
module clock_set_ctrl #(
    parameter logic [7:0] ALARM_HH_INIT = 8'h06,
    parameter logic [7:0] ALARM_MM_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_alarm,
    input  logic       btn_inc,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic [7:0] cur_ss,
    output logic       run_en,
    output logic       load,
    output logic [7:0] ld_hh,
    output logic [7:0] ld_mm,
    output logic [7:0] ld_ss,
    output logic [2:0] state,
    output logic       blink,
    output logic       alarm_hit
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HH = 3'd1,
        SET_MM = 3'd2,
        SET_SS = 3'd3,
        COMMIT = 3'd4,
        AL_HH  = 3'd5,
        AL_MM  = 3'd6
    } state_t;

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] edit_hh, edit_mm, edit_ss;
    logic [7:0] edit_hh_n, edit_mm_n, edit_ss_n;
    logic [7:0] al_hh, al_mm;
    logic [7:0] al_hh_n, al_mm_n;
    logic       in_set;
    logic       match_now;
    logic       match_prev;

    // BCD increment with wrap at 'limit'. Anything at or beyond the limit
    // (including garbage captured from the counter) wraps to zero, and a low
    // digit of 9 or more carries, so the result is always valid BCD.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] limit);
        logic [7:0] r;
        if (v >= limit) begin
            r = 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign state  = cur_state;
    assign in_set = (cur_state == SET_HH) || (cur_state == SET_MM) || (cur_state == SET_SS) ||
                    (cur_state == AL_HH)  || (cur_state == AL_MM);

    // Alarm condition; forced false outside RUN so the edge detector also sees 0 there.
    assign match_now = (cur_state == RUN) && (cur_hh == al_hh) && (cur_mm == al_mm) &&
                       (cur_ss == 8'h00);

    // Next-state and field-edit logic; an advance button always beats btn_inc.
    always_comb begin
        next_state = cur_state;
        edit_hh_n  = edit_hh;
        edit_mm_n  = edit_mm;
        edit_ss_n  = edit_ss;
        al_hh_n    = al_hh;
        al_mm_n    = al_mm;
        case (cur_state)
            RUN: begin
                if (btn_mode) begin
                    next_state = SET_HH;
                    edit_hh_n  = cur_hh;
                    edit_mm_n  = cur_mm;
                    edit_ss_n  = cur_ss;
                end else if (btn_alarm) begin
                    next_state = AL_HH;
                end
            end
            SET_HH: begin
                if (btn_mode)     next_state = SET_MM;
                else if (btn_inc) edit_hh_n  = bcd_inc(edit_hh, 8'h23);
            end
            SET_MM: begin
                if (btn_mode)     next_state = SET_SS;
                else if (btn_inc) edit_mm_n  = bcd_inc(edit_mm, 8'h59);
            end
            SET_SS: begin
                if (btn_mode)     next_state = COMMIT;
                else if (btn_inc) edit_ss_n  = bcd_inc(edit_ss, 8'h59);
            end
            COMMIT: begin
                next_state = RUN;
            end
            AL_HH: begin
                if (btn_alarm)    next_state = AL_MM;
                else if (btn_inc) al_hh_n    = bcd_inc(al_hh, 8'h23);
            end
            AL_MM: begin
                if (btn_alarm)    next_state = RUN;
                else if (btn_inc) al_mm_n    = bcd_inc(al_mm, 8'h59);
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // State, edit/alarm registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= RUN;
            edit_hh    <= 8'h00;
            edit_mm    <= 8'h00;
            edit_ss    <= 8'h00;
            al_hh      <= ALARM_HH_INIT;
            al_mm      <= ALARM_MM_INIT;
            run_en     <= 1'b1;
            load       <= 1'b0;
            ld_hh      <= 8'h00;
            ld_mm      <= 8'h00;
            ld_ss      <= 8'h00;
            blink      <= 1'b0;
            match_prev <= 1'b0;
            alarm_hit  <= 1'b0;
        end else begin
            cur_state  <= next_state;
            edit_hh    <= edit_hh_n;
            edit_mm    <= edit_mm_n;
            edit_ss    <= edit_ss_n;
            al_hh      <= al_hh_n;
            al_mm      <= al_mm_n;
            run_en     <= (next_state == RUN);
            load       <= (next_state == COMMIT);
            if (next_state == COMMIT) begin
                ld_hh <= edit_hh;
                ld_mm <= edit_mm;
                ld_ss <= edit_ss;
            end
            if (next_state != cur_state) begin
                blink <= 1'b0;
            end else if (in_set) begin
                if (tick) blink <= ~blink;
            end else begin
                blink <= 1'b0;
            end
            match_prev <= match_now;
            alarm_hit  <= match_now && !match_prev;
        end
    end

endmodule
